prom_loader: RTL and testbench

//  Boot-time program loader upstream of the CPU core. Takes a byte stream from a UART

---
 rtl/prom_loader_if.sv | 27 ++
 rtl/prom_loader.sv | 195 +++++++++++++++++++
 tb/tb_prom_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/prom_loader_if.sv
// Byte-in / program-RAM-write bundle of the boot loader.
interface prom_loader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 15
);
  logic [7:0]        rx_data_ip;
  logic              rx_valid_ip;
  logic              prom_we_op;
  logic [ADDR_W-1:0] prom_waddr_op;
  logic [DATA_W-1:0] prom_wdata_op;

  modport master (
    input  rx_data_ip,
    input  rx_valid_ip,
    output prom_we_op,
    output prom_waddr_op,
    output prom_wdata_op
  );

  modport slave (
    output rx_data_ip,
    output rx_valid_ip,
    input  prom_we_op,
    input  prom_waddr_op,
    input  prom_wdata_op
  );
endinterface

// File: rtl/prom_loader.sv
// Boot loader: frames UART bytes into 15-bit words, writes program RAM,
// holds the CPU in reset until the frame checksum verifies.
module prom_loader #(
  parameter int         ADDR_W      = 13,
  parameter int         DATA_W      = 15,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000
) (
  input  logic         CLK_ip,
  input  logic         reset,
  prom_loader_if.master bus,
  output logic         cpu_reset_n_op,
  output logic         busy_op,
  output logic         done_op,
  output logic         err_op,
  output logic [2:0]   err_code_op
);

  localparam int IW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_LEN  = 3'd1;
  localparam logic [2:0] E_FMT  = 3'd2;
  localparam logic [2:0] E_SUM  = 3'd3;
  localparam logic [2:0] E_TMO  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_W_L,
    S_W_H,
    S_CSUM,
    S_ERR
  } state_t;

  state_t state, state_n;

  logic [7:0]        len_h, len_h_n;
  logic [15:0]       len, len_n;
  logic [IW-1:0]     idx, idx_n;
  logic [7:0]        wl, wl_n;
  logic [7:0]        csum, csum_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              busy_n, done_n, err_n;
  logic [2:0]        code_n;
  logic              fail;
  logic [2:0]        fcode;
  logic [15:0]       n_w;
  logic [16:0]       idx_nx;
  logic [7:0]        b;
  logic              in_frame;

  assign b        = bus.rx_data_ip;
  assign n_w      = {len_h, b};
  assign idx_nx   = 17'(idx) + 17'd1;
  assign in_frame = (state != S_IDLE) && (state != S_ERR);

  always_comb begin
    state_n = state;
    len_h_n = len_h;
    len_n   = len;
    idx_n   = idx;
    wl_n    = wl;
    csum_n  = csum;
    tcnt_n  = tcnt;
    we_n    = 1'b0;
    waddr_n = bus.prom_waddr_op;
    wdata_n = bus.prom_wdata_op;
    busy_n  = busy_op;
    done_n  = done_op;
    err_n   = err_op;
    code_n  = err_code_op;
    fail    = 1'b0;
    fcode   = E_NONE;
    if (bus.rx_valid_ip) begin
      tcnt_n = '0;
      unique case (state)
        S_IDLE, S_ERR: begin
          if (b == SYNC_BYTE) begin
            state_n = S_LEN_H;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            err_n   = 1'b0;
            code_n  = E_NONE;
            csum_n  = '0;
            idx_n   = '0;
          end
        end
        S_LEN_H: begin
          len_h_n = b;
          csum_n  = csum + b;
          state_n = S_LEN_L;
        end
        S_LEN_L: begin
          csum_n = csum + b;
          len_n  = n_w;
          if (n_w == 16'd0 || {1'b0, n_w} > DEPTH) begin
            fail  = 1'b1;
            fcode = E_LEN;
          end else begin
            state_n = S_W_L;
          end
        end
        S_W_L: begin
          wl_n    = b;
          csum_n  = csum + b;
          state_n = S_W_H;
        end
        S_W_H: begin
          if (b[7]) begin
            fail  = 1'b1;
            fcode = E_FMT;
          end else begin
            we_n    = 1'b1;
            waddr_n = idx[ADDR_W-1:0];
            wdata_n = {b[6:0], wl};
            idx_n   = idx + 1'b1;
            csum_n  = csum + b;
            state_n = (idx_nx == {1'b0, len}) ? S_CSUM : S_W_L;
          end
        end
        S_CSUM: begin
          if (b == csum) begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            fail  = 1'b1;
            fcode = E_SUM;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (in_frame) begin
      // a byte on the expiry cycle takes the branch above instead
      if (tcnt == T_LAST) begin
        fail  = 1'b1;
        fcode = E_TMO;
      end else begin
        tcnt_n = tcnt + 1'b1;
      end
    end
    if (fail) begin
      state_n = S_ERR;
      busy_n  = 1'b0;
      err_n   = 1'b1;
      code_n  = fcode;
    end
  end

  always_ff @(posedge CLK_ip) begin
    if (reset) begin
      state             <= S_IDLE;
      len_h             <= '0;
      len               <= '0;
      idx               <= '0;
      wl                <= '0;
      csum              <= '0;
      tcnt              <= '0;
      bus.prom_we_op    <= 1'b0;
      bus.prom_waddr_op <= '0;
      bus.prom_wdata_op <= '0;
      busy_op           <= 1'b0;
      done_op           <= 1'b0;
      err_op            <= 1'b0;
      err_code_op       <= E_NONE;
      cpu_reset_n_op    <= 1'b0;
    end else begin
      state             <= state_n;
      len_h             <= len_h_n;
      len               <= len_n;
      idx               <= idx_n;
      wl                <= wl_n;
      csum              <= csum_n;
      tcnt              <= tcnt_n;
      bus.prom_we_op    <= we_n;
      bus.prom_waddr_op <= waddr_n;
      bus.prom_wdata_op <= wdata_n;
      busy_op           <= busy_n;
      done_op           <= done_n;
      err_op            <= err_n;
      err_code_op       <= code_n;
      // CPU runs only while idle; the final write precedes the CSUM byte
      cpu_reset_n_op    <= (state_n == S_IDLE);
    end
  end

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader: framing, length/format/checksum/
// timeout errors, mid-frame reset and recovery from the error state.
module tb_prom_loader;

  localparam int AW = 13;
  localparam int DW = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_rst_n, busy, done, err;
  logic [2:0] code;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  logic [7:0]    f[$];

  prom_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  prom_loader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(16)
  ) dut (
    .CLK_ip(clk),
    .reset(reset),
    .bus(bus),
    .cpu_reset_n_op(cpu_rst_n),
    .busy_op(busy),
    .done_op(done),
    .err_op(err),
    .err_code_op(code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.prom_we_op) begin
      wa.push_back(bus.prom_waddr_op);
      wd.push_back(bus.prom_wdata_op);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st();
    return {25'd0, cpu_rst_n, busy, done, err, code};
  endfunction

  function automatic logic [31:0] mk(input logic c, input logic b,
                                     input logic d, input logic e,
                                     input logic [2:0] k);
    return {25'd0, c, b, d, e, k};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    @(negedge clk);
    bus.rx_data_ip  = v;
    bus.rx_valid_ip = 1'b1;
    @(negedge clk);
    bus.rx_valid_ip = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic chk_wr(input string tag, input int i,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    if (wa.size() > i)
      check(tag, {4'd0, wa[i], wd[i]}, {4'd0, a, d});
    else
      check(tag, 32'(wa.size()), 32'(i + 1));
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    bus.rx_data_ip  = 8'h00;
    bus.rx_valid_ip = 1'b0;
    idle(3);
    check("rst_status", st(), mk(0, 0, 0, 0, 0));
    check("rst_we", 32'(bus.prom_we_op), 32'd0);
    check("rst_waddr", 32'(bus.prom_waddr_op), 32'd0);
    check("rst_wdata", 32'(bus.prom_wdata_op), 32'd0);
    reset = 1'b0;
    idle(1);
    check("rst_release", st(), mk(1, 0, 0, 0, 0));

    // T1 two-word frame
    send_byte(8'hA5);
    check("t1_busy", st(), mk(0, 1, 0, 0, 0));
    f = '{8'h00, 8'h02, 8'h34, 8'h12, 8'h78};
    send_seq(f);
    send_byte(8'h56);
    check("t1_we_lat",
          {3'd0, bus.prom_we_op, bus.prom_waddr_op, bus.prom_wdata_op},
          {3'd0, 1'b1, 13'd1, 15'h5678});
    send_byte(8'h16);
    check("t1_done", st(), mk(1, 0, 1, 0, 0));
    idle(2);
    check("t1_nwr", 32'(wa.size()), 32'd2);
    chk_wr("t1_w0", 0, 13'd0, 15'h1234);
    chk_wr("t1_w1", 1, 13'd1, 15'h5678);
    clr();

    // T2 single word, good then bad checksum
    f = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'h7F, 8'h7F};
    send_seq(f);
    check("t2_done", st(), mk(1, 0, 1, 0, 0));
    idle(2);
    check("t2_nwr", 32'(wa.size()), 32'd1);
    chk_wr("t2_w0", 0, 13'd0, 15'h7FFF);
    f = '{8'hA5, 8'h00, 8'h01, 8'hFF, 8'h7F, 8'h00};
    send_seq(f);
    check("t2_csum_err", st(), mk(0, 0, 0, 1, 3));
    idle(2);
    clr();

    // T3 bad word format, bad lengths, max length accepted
    f = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h80};
    send_seq(f);
    idle(2);
    check("t3_fmt_err", st(), mk(0, 0, 0, 1, 2));
    check("t3_no_wr", 32'(wa.size()), 32'd0);
    f = '{8'hA5, 8'h00, 8'h00};
    send_seq(f);
    check("t3_len0", st(), mk(0, 0, 0, 1, 1));
    f = '{8'hA5, 8'h20, 8'h01};
    send_seq(f);
    check("t3_len2001", st(), mk(0, 0, 0, 1, 1));
    f = '{8'hA5, 8'h20, 8'h00};
    send_seq(f);
    check("t3_len2000", st(), mk(0, 1, 0, 0, 0));
    idle(17);
    check("t3_len2000_tmo", st(), mk(0, 0, 0, 1, 4));

    // T4 timeout boundary
    f = '{8'hA5, 8'h00};
    send_seq(f);
    idle(15);
    check("t4_pre_tmo", st(), mk(0, 1, 0, 0, 0));
    idle(1);
    check("t4_tmo", st(), mk(0, 0, 0, 1, 4));
    f = '{8'hA5, 8'h00};
    send_seq(f);
    idle(14);
    send_byte(8'h01);
    check("t4_byte_wins", st(), mk(0, 1, 0, 0, 0));
    f = '{8'h34, 8'h12, 8'h47};
    send_seq(f);
    check("t4_done", st(), mk(1, 0, 1, 0, 0));
    idle(2);
    clr();

    // T5 reset mid-frame, then reload
    f = '{8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78};
    send_seq(f);
    reset = 1'b1;
    idle(1);
    check("t5_rst_status", st(), mk(0, 0, 0, 0, 0));
    check("t5_rst_bus",
          {3'd0, bus.prom_we_op, bus.prom_waddr_op, bus.prom_wdata_op},
          32'd0);
    reset = 1'b0;
    idle(1);
    check("t5_release", st(), mk(1, 0, 0, 0, 0));
    clr();
    f = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h68};
    send_seq(f);
    check("t5_done", st(), mk(1, 0, 1, 0, 0));
    idle(2);
    check("t5_nwr", 32'(wa.size()), 32'd2);
    chk_wr("t5_w0", 0, 13'd0, 15'h1111);
    chk_wr("t5_w1", 1, 13'd1, 15'h2222);
    clr();

    // T6 garbage in ERR, then recovery
    f = '{8'hA5, 8'h00, 8'h00};
    send_seq(f);
    check("t6_err", st(), mk(0, 0, 0, 1, 1));
    f = '{8'h00, 8'h11};
    send_seq(f);
    idle(3);
    check("t6_still_err", st(), mk(0, 0, 0, 1, 1));
    f = '{8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    send_seq(f);
    check("t6_recover", st(), mk(1, 0, 1, 0, 0));
    idle(2);
    chk_wr("t6_w0", 0, 13'd0, 15'h1234);
    chk_wr("t6_w1", 1, 13'd1, 15'h5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
